// File: rtl/neuron_row_mac.sv
// neuron_row_mac
// Sequencer plus multiply-accumulate stage for one neuron row. On START it sweeps
// addresses 0..DEPTH-1 into a negedge-read weight BRAM and the matching input-row
// buffer. It accumulates signed Q8.8 weight x input products into a wide
// accumulator. It then adds the latched bias, applies an optional ReLU and
// saturates to a 16-bit Q8.8 result.
//
// Ports
//   CLK     : single clock, all state updates on the rising edge
//   RST     : synchronous active-high reset
//   START   : begin a row (only honoured in IDLE)
//   BIAS    : signed Q8.8 bias, captured when START is accepted
//   W_DO    : weight BRAM read data
//   X_DO    : input-row buffer read data
//   ADDR    : shared read address to both memories
//   EN      : memory enable
//   WE      : memory write enable, always 0
//   BUSY    : high from START acceptance until DONE
//   DONE    : one-cycle pulse, RESULT valid
//   RESULT  : final Q8.8 value, held until the next DONE
module neuron_row_mac #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int ACC_W  = 37,
    parameter bit RELU   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] BIAS,
    input  logic [DATA_W-1:0] W_DO,
    input  logic [DATA_W-1:0] X_DO,
    output logic [ADDR_W-1:0] ADDR,
    output logic              EN,
    output logic              WE,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RESULT
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic [ADDR_W-1:0]          addr_nxt_s;
    logic                       en_nxt_s;
    logic                       busy_nxt_s;
    logic                       done_nxt_s;
    logic [DATA_W-1:0]          result_nxt_s;
    logic [DATA_W-1:0]          bias_r;
    logic [DATA_W-1:0]          bias_nxt_s;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    acc_nxt_s;
    logic signed [PROD_W-1:0]   prod_s;

    // Shift the accumulator back to Q8.8 (floor), add bias, optional ReLU, saturate.
    function automatic logic [DATA_W-1:0] finalize(
        input logic signed [ACC_W-1:0] acc,
        input logic [DATA_W-1:0]       bias
    );
        logic signed [ACC_W-1:0] shr;
        logic signed [SUM_W-1:0] sum;
        logic [SUM_W-DATA_W:0]   top;
        logic [DATA_W-1:0]       res;
        shr = acc >>> FRAC;
        sum = {shr[ACC_W-1], shr} + {{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias};
        if (RELU && sum[SUM_W-1]) begin
            sum = {SUM_W{1'b0}};
        end else begin
            sum = sum;
        end
        // The value fits in DATA_W bits when every bit from the result sign upward agrees.
        top = sum[SUM_W-1:DATA_W-1];
        if ((&top) || (~|top)) begin
            res = sum[DATA_W-1:0];
        end else if (sum[SUM_W-1]) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end
        return res;
    endfunction

    assign prod_s = $signed(W_DO) * $signed(X_DO);
    assign WE     = 1'b0;

    // Next-state, next-output and accumulator update logic.
    always_comb begin
        state_nxt_s  = state_r;
        addr_nxt_s   = ADDR;
        en_nxt_s     = EN;
        busy_nxt_s   = BUSY;
        done_nxt_s   = 1'b0;
        result_nxt_s = RESULT;
        bias_nxt_s   = bias_r;
        // EN is registered, so it is high exactly on the edges where the memory
        // output holds data for an address that was enabled one cycle earlier.
        if (EN) begin
            acc_nxt_s = acc_r + {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
        end else begin
            acc_nxt_s = acc_r;
        end

        case (state_r)
            S_IDLE: begin
                if (START) begin
                    state_nxt_s = S_RUN;
                    addr_nxt_s  = {ADDR_W{1'b0}};
                    en_nxt_s    = 1'b1;
                    busy_nxt_s  = 1'b1;
                    bias_nxt_s  = BIAS;
                    acc_nxt_s   = {ACC_W{1'b0}};
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (ADDR == LAST_ADDR) begin
                    state_nxt_s = S_LAST;
                    en_nxt_s    = 1'b0;
                end else begin
                    addr_nxt_s  = ADDR + ADDR_W'(1);
                end
            end
            S_LAST: begin
                // Data for the last address was accumulated on the previous edge.
                state_nxt_s  = S_DONE;
                result_nxt_s = finalize(acc_r, bias_r);
                done_nxt_s   = 1'b1;
                busy_nxt_s   = 1'b0;
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
                en_nxt_s    = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, output and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            ADDR    <= {ADDR_W{1'b0}};
            EN      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= {DATA_W{1'b0}};
            bias_r  <= {DATA_W{1'b0}};
            acc_r   <= {ACC_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ADDR    <= addr_nxt_s;
            EN      <= en_nxt_s;
            BUSY    <= busy_nxt_s;
            DONE    <= done_nxt_s;
            RESULT  <= result_nxt_s;
            bias_r  <= bias_nxt_s;
            acc_r   <= acc_nxt_s;
        end
    end

endmodule
